// File: rtl/mem_arbiter_if.sv
// Bus bundle between two requesters (cpu, dbg), the arbiter and a synchronous SRAM.
// slave = arbiter side, master = requester/memory side.
interface mem_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_done;
  logic        dbg_req;
  logic        dbg_we;
  logic [15:0] dbg_addr;
  logic [15:0] dbg_wdata;
  logic [15:0] dbg_rdata;
  logic        dbg_done;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        Mem_OE;
  logic        Mem_WE;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_done, dbg_rdata, dbg_done,
    output mem_addr, mem_wdata, Mem_OE, Mem_WE
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_done, dbg_rdata, dbg_done,
    input  mem_addr, mem_wdata, Mem_OE, Mem_WE
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester SRAM arbiter: IDLE -> ACCESS (WAIT_CYCLES) -> DONE -> IDLE.
// Define MEM_ARBITER_ROUND_ROBIN_EN for alternating grants; default build gives cpu fixed priority.
//
// state  | meaning
// IDLE   | waiting for a request; grant and latch on the edge leaving
// ACCESS | memory enables held for WAIT_CYCLES cycles from latched request
// DONE   | one-cycle done pulse to the granted requester, enables off
module mem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        last_cyc;
  logic        any_req;
  logic        grant_dbg;
  logic        grant_dbg_nxt;
  logic        lat_we;
  logic [15:0] lat_addr;
  logic [15:0] lat_wdata;
  logic [15:0] cpu_rdata_q;
  logic [15:0] dbg_rdata_q;
  logic        mem_oe;
  logic        mem_we;
  logic        cpu_done;
  logic        dbg_done;

  assign any_req  = bus.cpu_req | bus.dbg_req;
  assign last_cyc = (cnt == LAST_CNT);

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic last_dbg;
  // On a tie the requester that lost last time wins.
  always_comb grant_dbg_nxt = bus.dbg_req & (~bus.cpu_req | ~last_dbg);
`else
  always_comb grant_dbg_nxt = ~bus.cpu_req;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_oe    = 1'b0;
    mem_we    = 1'b0;
    cpu_done  = 1'b0;
    dbg_done  = 1'b0;
    case (state)
      IDLE:   if (any_req) state_nxt = ACCESS;
      ACCESS: begin
        mem_oe = 1'b1;
        mem_we = lat_we;
        if (last_cyc) state_nxt = DONE;
      end
      DONE: begin
        cpu_done  = ~grant_dbg;
        dbg_done  = grant_dbg;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt         <= 4'd0;
      grant_dbg   <= 1'b0;
      lat_we      <= 1'b0;
      lat_addr    <= 16'd0;
      lat_wdata   <= 16'd0;
      cpu_rdata_q <= 16'd0;
      dbg_rdata_q <= 16'd0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      last_dbg    <= 1'b1;
`endif
    end else if (state == IDLE && any_req) begin
      cnt       <= 4'd0;
      grant_dbg <= grant_dbg_nxt;
      lat_we    <= grant_dbg_nxt ? bus.dbg_we    : bus.cpu_we;
      lat_addr  <= grant_dbg_nxt ? bus.dbg_addr  : bus.cpu_addr;
      lat_wdata <= grant_dbg_nxt ? bus.dbg_wdata : bus.cpu_wdata;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      last_dbg  <= grant_dbg_nxt;
`endif
    end else if (state == ACCESS) begin
      cnt <= cnt + 4'd1;
      if (last_cyc && !lat_we) begin
        if (grant_dbg) dbg_rdata_q <= bus.mem_rdata;
        else           cpu_rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_addr  = lat_addr;
  assign bus.mem_wdata = lat_wdata;
  assign bus.Mem_OE    = mem_oe;
  assign bus.Mem_WE    = mem_we;
  assign bus.cpu_done  = cpu_done;
  assign bus.dbg_done  = dbg_done;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dbg_rdata = dbg_rdata_q;

endmodule
